// File: rtl/rgb_hsv_seq.sv
// Multi-cycle RGB888 -> packed HSV {H[8:0], S[6:0], V[7:0]} converter with one shared restoring divider.
// Optional HSV_ROUND_EN: both divisions round to nearest instead of truncating.
module rgb_hsv_seq #(
    parameter int unsigned S_SCALE = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] hsv,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned DIV_ITER = 15;
    localparam int unsigned CW       = 8;
    localparam int unsigned NW       = 15;
    localparam int unsigned HW       = 9;
    localparam int unsigned SW       = 7;
    localparam int unsigned KW       = 4;

    typedef enum logic [2:0] {IDLE, PREP, DIV_S, DIV_H, FINAL, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
    logic [CW-1:0]   max_q, max_d, delta_q, delta_d, dabs_q, dabs_d;
    logic [HW-1:0]   off_q, off_d;
    logic            dneg_q, dneg_d;
    logic [NW-1:0]   num_q, num_d;
    logic [CW-1:0]   div_q, div_d, rem_q, rem_d;
    logic [SW-1:0]   quo_q, quo_d, s_q, s_d;
    logic [KW-1:0]   cnt_q, cnt_d;
    logic [23:0]     hsv_q, hsv_d;
    logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    logic [CW:0]     rem_sh;
    logic            q_bit;
    logic [CW-1:0]   rem_step;
    logic [SW-1:0]   quo_step;
    logic [CW-1:0]   mx, mn, da, db;
    logic [HW-1:0]   sec_off, hq, h_fin;
    logic [NW-1:0]   num_s, num_h;
    logic            last_iter;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign hsv       = hsv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            max_q       <= '0;
            delta_q     <= '0;
            dabs_q      <= '0;
            off_q       <= '0;
            dneg_q      <= 1'b0;
            num_q       <= '0;
            div_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            s_q         <= '0;
            cnt_q       <= '0;
            hsv_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            max_q       <= max_d;
            delta_q     <= delta_d;
            dabs_q      <= dabs_d;
            off_q       <= off_d;
            dneg_q      <= dneg_d;
            num_q       <= num_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            hsv_q       <= hsv_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        g_d      = g_q;
        b_d      = b_q;
        max_d    = max_q;
        delta_d  = delta_q;
        dabs_d   = dabs_q;
        off_d    = off_q;
        dneg_d   = dneg_q;
        num_d    = num_q;
        div_d    = div_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        hsv_d    = hsv_q;

        // One restoring step; a zero divisor never sets a quotient bit.
        rem_sh   = {rem_q, num_q[NW-1]};
        q_bit    = (div_q != '0) && (rem_sh >= {1'b0, div_q});
        rem_step = q_bit ? CW'(rem_sh - {1'b0, div_q}) : rem_sh[CW-1:0];
        quo_step = {quo_q[SW-2:0], q_bit};
        last_iter = (cnt_q == KW'(DIV_ITER - 1));

        // Sector selection with tie priority R > G > B.
        if (r_q >= g_q && r_q >= b_q) begin
            mx = r_q; sec_off = HW'(0);   da = g_q; db = b_q;
        end else if (g_q >= b_q) begin
            mx = g_q; sec_off = HW'(120); da = b_q; db = r_q;
        end else begin
            mx = b_q; sec_off = HW'(240); da = r_q; db = g_q;
        end
        mn = (r_q < g_q) ? r_q : g_q;
        if (b_q < mn) mn = b_q;

`ifdef HSV_ROUND_EN
        num_s = NW'(delta_q) * NW'(S_SCALE) + NW'(max_q >> 1);
        num_h = NW'(dabs_q) * NW'(60) + NW'(delta_q >> 1);
`else
        num_s = NW'(delta_q) * NW'(S_SCALE);
        num_h = NW'(dabs_q) * NW'(60);
`endif

        hq = {2'b00, quo_q};
        if (!dneg_q)
            h_fin = off_q + hq;
        else if (off_q >= hq)
            h_fin = off_q - hq;
        else
            h_fin = HW'(10'(off_q) + 10'd360 - 10'(hq));

        case (state_q)
            IDLE: if (in_valid) begin
                r_d = in_r; g_d = in_g; b_d = in_b;
                cnt_d   = '0;
                state_d = PREP;
            end
            PREP: if (cnt_q == '0) begin
                max_d   = mx;
                delta_d = mx - mn;
                off_d   = sec_off;
                dneg_d  = da < db;
                dabs_d  = (da < db) ? db - da : da - db;
                cnt_d   = KW'(1);
            end else begin
                num_d   = num_s;
                div_d   = max_q;
                rem_d   = '0;
                quo_d   = '0;
                cnt_d   = '0;
                state_d = DIV_S;
            end
            DIV_S: begin
                num_d = {num_q[NW-2:0], 1'b0};
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + KW'(1);
                if (last_iter) begin
                    s_d     = quo_step;
                    num_d   = num_h;
                    div_d   = delta_q;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = DIV_H;
                end
            end
            DIV_H: begin
                num_d = {num_q[NW-2:0], 1'b0};
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + KW'(1);
                if (last_iter) state_d = FINAL;
            end
            FINAL: begin
                hsv_d   = {h_fin, s_q, max_q};
                state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_rgb_hsv_seq.sv
// Self-checking bench for rgb_hsv_seq: directed, random, backpressure and reset-abort scenarios.
module tb_rgb_hsv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_r, in_g, in_b;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] hsv;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    rgb_hsv_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hsv       (hsv),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] model(input int r, input int g, input int b);
        int mx, mn, dl, d, off, ad, s, q, h;
        mx = (r > g) ? r : g; if (b > mx) mx = b;
        mn = (r < g) ? r : g; if (b < mn) mn = b;
        dl = mx - mn;
        if (r >= g && r >= b) begin d = g - b; off = 0; end
        else if (g >= b)      begin d = b - r; off = 120; end
        else                  begin d = r - g; off = 240; end
        ad = (d < 0) ? -d : d;
`ifdef HSV_ROUND_EN
        s = (mx == 0) ? 0 : (dl * 127 + mx / 2) / mx;
        q = (dl == 0) ? 0 : (60 * ad + dl / 2) / dl;
`else
        s = (mx == 0) ? 0 : (dl * 127) / mx;
        q = (dl == 0) ? 0 : (60 * ad) / dl;
`endif
        h = (d >= 0) ? off + q : off - q;
        if (h < 0) h = h + 360;
        return {9'(h), 7'(s), 8'(mx)};
    endfunction

    // Full transaction with out_ready held high; returns result and cycles from accept to out_valid.
    task automatic convert(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           output logic [23:0] res, output int lat);
        int n;
        in_r = r; in_g = g; in_b = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        res = hsv;
        @(posedge clk); #1;
    endtask

    task automatic check_pixel(input string name, input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b, input logic [23:0] exp_val);
        logic [23:0] res;
        int lat;
        convert(r, g, b, res, lat);
        n_checks++;
        if (res !== exp_val) begin
            n_fail++;
            $display("FAIL %s value (%0d,%0d,%0d): got %h expected %h", name, r, g, b, res, exp_val);
        end
        n_checks++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected 33", name, lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_r = '0; in_g = '0; in_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || hsv !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b hsv=%h expected 1 0 000000",
                     in_ready, out_valid, hsv);
        end
    endtask

    task automatic test_directed();
        check_pixel("red",   8'd255, 8'd0,   8'd0,   24'h007FFF);
        check_pixel("green", 8'd0,   8'd255, 8'd0,   24'h3C7FFF);
        check_pixel("blue",  8'd0,   8'd0,   8'd255, 24'h787FFF);
        check_pixel("grey",  8'd128, 8'd128, 8'd128, 24'h000080);
        check_pixel("black", 8'd0,   8'd0,   8'd0,   24'h000000);
        check_pixel("wrap",  8'd255, 8'd0,   8'd128, 24'hA57FFF);
        check_pixel("mixed", 8'd200, 8'd100, 8'd50,  24'h0A5FC8);
    endtask

    task automatic test_random();
        logic [7:0] r, g, b;
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) begin
                r = 8'($urandom_range(0, 3) * 85);
                g = 8'($urandom_range(0, 3) * 85);
                b = 8'($urandom_range(0, 3) * 85);
            end else begin
                r = 8'($urandom_range(0, 255));
                g = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
            end
            check_pixel("random", r, g, b, model(int'(r), int'(g), int'(b)));
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] held;
        int lat;
        out_ready = 1'b0;
        in_r = 8'd10; in_g = 8'd200; in_b = 8'd90; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        held = hsv;
        n_checks++;
        if (held !== model(10, 200, 90)) begin
            n_fail++;
            $display("FAIL bp_value: got %h expected %h", held, model(10, 200, 90));
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            in_r = 8'($urandom_range(0, 255)); in_g = 8'd0; in_b = 8'd0;
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || hsv !== held || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b hsv=%h in_ready=%b expected 1 %h 0",
                         k, out_valid, hsv, in_ready, held);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        check_pixel("after_bp", 8'd30, 8'd60, 8'd240, model(30, 60, 240));
    endtask

    task automatic test_reset_mid();
        in_r = 8'd255; in_g = 8'd0; in_b = 8'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || hsv !== 24'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: out_valid=%b hsv=%h in_ready=%b expected 0 000000 1",
                     out_valid, hsv, in_ready);
        end
        check_pixel("after_rst", 8'd200, 8'd100, 8'd50, 24'h0A5FC8);
    endtask

    task automatic test_back_to_back();
        logic [23:0] r1, r2;
        int l1, l2;
        convert(8'd17, 8'd99, 8'd99, r1, l1);
        convert(8'd99, 8'd99, 8'd17, r2, l2);
        n_checks++;
        if (r1 !== model(17, 99, 99) || l1 !== 33) begin
            n_fail++;
            $display("FAIL b2b_first: got %h lat %0d expected %h lat 33", r1, l1, model(17, 99, 99));
        end
        n_checks++;
        if (r2 !== model(99, 99, 17) || l2 !== 33) begin
            n_fail++;
            $display("FAIL b2b_second: got %h lat %0d expected %h lat 33", r2, l2, model(99, 99, 17));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
